// File: rtl/lcd_bus_driver.sv
// HD44780-style parallel bus driver. After reset it runs the power-on wait and
// the four-entry init sequence, then accepts one byte per valid/ready handshake
// and sequences address setup, enable pulse, hold and execution wait on its own.
module lcd_bus_driver #(
    parameter int unsigned POWERON_CYC    = 750000,
    parameter int unsigned T_AS_CYC       = 2,
    parameter int unsigned T_EH_CYC       = 13,
    parameter int unsigned T_H_CYC        = 1,
    parameter int unsigned WAIT_SHORT_CYC = 2000,
    parameter int unsigned WAIT_LONG_CYC  = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       lcd_on
);

    // A zero-length phase makes no sense on the bus; it is stretched to one cycle.
    function automatic int unsigned eff(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned PwrEff   = eff(POWERON_CYC);
    localparam int unsigned AsEff    = eff(T_AS_CYC);
    localparam int unsigned EhEff    = eff(T_EH_CYC);
    localparam int unsigned HEff     = eff(T_H_CYC);
    localparam int unsigned ShortEff = eff(WAIT_SHORT_CYC);
    localparam int unsigned LongEff  = eff(WAIT_LONG_CYC);
    localparam int unsigned MaxCyc   = max2(max2(max2(PwrEff, AsEff), max2(EhEff, HEff)),
                                            max2(ShortEff, LongEff));
    localparam int unsigned CntW     = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [CntW-1:0] PwrLast   = CntW'(PwrEff - 1);
    localparam logic [CntW-1:0] AsLast    = CntW'(AsEff - 1);
    localparam logic [CntW-1:0] EhLast    = CntW'(EhEff - 1);
    localparam logic [CntW-1:0] HLast     = CntW'(HEff - 1);
    localparam logic [CntW-1:0] ShortLast = CntW'(ShortEff - 1);
    localparam logic [CntW-1:0] LongLast  = CntW'(LongEff - 1);

    typedef enum logic [2:0] {
        StPwrWait,
        StInitLoad,
        StIdle,
        StSetup,
        StEHigh,
        StHold,
        StExecWait
    } state_e;

    // Init ROM: function set, display on, entry mode, clear.
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] val;
        unique case (idx)
            2'd0:    val = 8'h38;
            2'd1:    val = 8'h0C;
            2'd2:    val = 8'h06;
            default: val = 8'h01;
        endcase
        return val;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic            init_done_q, init_done_d;
    logic            lcd_en_q, lcd_en_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;

    logic accept;
    logic long_wait;

    assign accept    = (state_q == StIdle) && req_valid && req_ready_q;
    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    assign long_wait = !lcd_rs_q && (lcd_data_q[7:2] == 6'b0);

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StPwrWait;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            lcd_en_q    <= lcd_en_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; the power-on wait counts up from reset, every other
    // phase loads its length minus one and counts down to zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        unique case (state_q)
            StPwrWait: begin
                if (cnt_q == PwrLast) begin
                    state_d = StInitLoad;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StInitLoad: begin
                state_d = StSetup;
                cnt_d   = AsLast;
            end
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = AsLast;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StEHigh;
                    cnt_d   = EhLast;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StEHigh: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = HLast;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StExecWait;
                    cnt_d   = long_wait ? LongLast : ShortLast;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StExecWait: begin
                if (cnt_q == '0) begin
                    if (init_done_q) begin
                        state_d = StIdle;
                    end else if (init_idx_q == 2'd3) begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end else begin
                        state_d    = StInitLoad;
                        init_idx_d = init_idx_q + 2'd1;
                        cnt_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StPwrWait;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values derived from the next state so every output is a flop.
    always_comb begin
        lcd_en_d    = (state_d == StEHigh);
        busy_d      = (state_d != StIdle);
        req_ready_d = (state_d == StIdle) && init_done_d;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        if (state_d == StInitLoad) begin
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_rom(init_idx_d);
        end else if (accept) begin
            lcd_rs_d   = req_rs;
            lcd_data_d = req_data;
        end
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign lcd_en    = lcd_en_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_rw    = 1'b0;
    assign lcd_on    = 1'b1;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver: expected bus bytes go into a queue when
// stimulus is driven and are popped on every observed enable pulse.
module tb_lcd_bus_driver;

    localparam int P_PWR   = 20;
    localparam int P_AS    = 2;
    localparam int P_EH    = 4;
    localparam int P_H     = 1;
    localparam int P_SHORT = 10;
    localparam int P_LONG  = 50;

    localparam int FIRST_EN = P_PWR + 1 + P_AS;
    localparam int LAT_S    = P_AS + P_EH + P_H + P_SHORT;
    localparam int LAT_L    = P_AS + P_EH + P_H + P_LONG;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       lcd_on;

    lcd_bus_driver #(
        .POWERON_CYC   (P_PWR),
        .T_AS_CYC      (P_AS),
        .T_EH_CYC      (P_EH),
        .T_H_CYC       (P_H),
        .WAIT_SHORT_CYC(P_SHORT),
        .WAIT_LONG_CYC (P_LONG)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .busy     (busy),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .lcd_on   (lcd_on)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];

    // Bus monitor state
    int         cyc       = 0;
    int         pulses    = 0;
    int         hi        = 0;
    int         run       = 0;
    int         last_fall = 0;
    logic       en_prev   = 1'b0;
    logic [8:0] last_bus  = '0;
    logic [8:0] pulse_bus = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point for the directed sequence: just after the falling edge, once
    // the monitor has processed that edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Watches the LCD bus: pops the scoreboard on each enable rise, checks setup,
    // pulse width and that rs/data are held through the pulse.
    always @(negedge clock) begin
        logic [8:0] bus;
        logic [8:0] e;
        cyc++;
        if (!reset) begin
            en_prev  = 1'b0;
            hi       = 0;
            run      = 0;
            last_bus = '0;
        end else begin
            bus = {lcd_rs, lcd_data};
            if (bus === last_bus) run++;
            else run = 1;
            last_bus = bus;
            if (lcd_en && !en_prev) begin
                pulses++;
                hi        = 1;
                pulse_bus = bus;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(bus), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_byte", 32'(bus), 32'(e));
                end
                chk("setup_time", 32'(run > P_AS), 1);
            end else if (lcd_en) begin
                hi++;
            end
            if (!lcd_en && en_prev) begin
                chk("en_width", hi, P_EH);
                chk("bus_hold", 32'(bus), 32'(pulse_bus));
                last_fall = cyc;
            end
            en_prev = lcd_en;
        end
    end

    task automatic push_rom();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    // Wait for ready, drive the byte through its accepting edge, check capture.
    task automatic accept(input logic rs, input logic [7:0] d);
        int n;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 5000) begin
            tick();
            n++;
        end
        chk("ready_before_accept", 32'(req_ready), 1);
        exp_q.push_back({rs, d});
        tick();
        req_valid = 1'b0;
        chk("capture", 32'({lcd_rs, lcd_data}), 32'({rs, d}));
        chk("ready_drop", 32'({req_ready, busy}), 32'b01);
    endtask

    task automatic wait_lat(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!req_ready && n < 5000) begin
            tick();
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    task automatic wait_init(input int p0);
        int n;
        n = 0;
        while (!init_done && n < 5000) begin
            tick();
            n++;
        end
        chk("init_done_delay", cyc - last_fall, P_H + P_LONG);
        chk("init_ready", 32'({init_done, req_ready, busy}), 32'b110);
        chk("init_pulses", pulses - p0, 4);
        chk("init_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int p0;
        logic [7:0] ch;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (3) tick();
        chk("rst_en", 32'(lcd_en), 0);
        chk("rst_bus", 32'({lcd_rs, lcd_data}), 0);
        chk("rst_flags", 32'({req_ready, init_done, busy}), 32'b001);
        chk("rst_rw_on", 32'({lcd_rw, lcd_on}), 32'b01);

        // Power-on and init, with a request held during init that must be ignored.
        push_rom();
        p0 = pulses;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'hAA;
        n = 0;
        while (!lcd_en && n < 1000) begin
            tick();
            n++;
        end
        chk("pwr_to_first_en", n, FIRST_EN);
        chk("init_no_capture", 32'({lcd_rs, lcd_data}), 32'h038);
        chk("init_not_ready", 32'(req_ready), 0);
        tick();
        req_valid = 1'b0;
        wait_init(p0);

        // Character accepted on the first edge; a request held during E_HIGH waits.
        accept(1'b1, 8'h31);
        n = 0;
        while (!lcd_en && n < 100) begin
            tick();
            n++;
        end
        chk("setup_cycles", n, P_AS);
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h80;
        tick();
        n++;
        chk("ehigh_no_capture", 32'({lcd_rs, lcd_data}), 32'h131);
        while (!req_ready && n < 5000) begin
            tick();
            n++;
        end
        chk("lat_char_31", n, LAT_S);
        accept(1'b0, 8'h80);
        wait_lat("lat_cmd_80", LAT_S);
        accept(1'b0, 8'h02);
        wait_lat("lat_cmd_02_home", LAT_L);
        accept(1'b0, 8'h03);
        wait_lat("lat_cmd_03_home", LAT_L);
        accept(1'b1, 8'h01);
        wait_lat("lat_data_01", LAT_S);
        accept(1'b0, 8'h04);
        wait_lat("lat_cmd_04", LAT_S);

        // Sixteen back-to-back characters '0'/'1'.
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            ch = 8'h30 + 8'($urandom_range(0, 1));
            accept(1'b1, ch);
        end
        wait_lat("lat_last_char", LAT_S);
        chk("b2b_pulses", pulses - p0, 16);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Reset asserted during E_HIGH takes effect before the next clock edge.
        accept(1'b1, 8'h41);
        n = 0;
        while (!lcd_en && n < 100) begin
            tick();
            n++;
        end
        tick();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_en", 32'(lcd_en), 0);
        chk("async_rst_bus", 32'({lcd_rs, lcd_data}), 0);
        chk("async_rst_flags", 32'({req_ready, init_done, busy}), 32'b001);
        exp_q.delete();
        push_rom();
        repeat (3) tick();
        p0 = pulses;
        reset = 1'b1;
        n = 0;
        while (!lcd_en && n < 1000) begin
            tick();
            n++;
        end
        chk("repwr_to_first_en", n, FIRST_EN);
        wait_init(p0);

        repeat (5) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Physical-interface stage directly downstream of the LCD entry writer. It accepts one LCD byte (command or character) per valid/ready handshake.
- It drives the HD44780-style parallel bus with correct address-setup, enable-pulse, hold and execution-wait timing.
- After reset it runs the power-on wait and the init command sequence by itself, then serves requests.
- Upstream writers no longer need to time the enable strobe or execution delays.

Parameters:
- POWERON_CYC, 750000, clock cycles to wait after reset before the first init command (15 ms at 50 MHz).
- T_AS_CYC, 2, cycles lcd_rs/lcd_data are stable before lcd_en rises.
- T_EH_CYC, 13, cycles lcd_en is held high.
- T_H_CYC, 1, cycles lcd_rs/lcd_data are held after lcd_en falls, before the wait phase.
- WAIT_SHORT_CYC, 2000, execution wait for normal commands and data writes (40 us).
- WAIT_LONG_CYC, 82000, execution wait for clear/home commands (1.64 ms).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream has a byte to send.
- req_rs  in  1  0 = command, 1 = character data.
- req_data  in  8  byte to send.
- req_ready  out  1  block can accept a byte this cycle.
- init_done  out  1  init sequence complete; stays 1 until reset.
- busy  out  1  high in every state except IDLE.
- lcd_en  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied 0, write only.
- lcd_data  out  8  LCD data bus.
- lcd_on  out  1  LCD power/backlight enable; constant 1.

Behaviour:
- Reset is asynchronous and active-low. While reset=0 and at deassertion: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcd_on=1, req_ready=0, init_done=0, busy=1, state=PWR_WAIT, counters=0.
- Reset mid-transfer aborts immediately; no completion of the in-flight byte. The next transfer after deassertion is the first init command.
- All outputs are registered.
- States: PWR_WAIT, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT.
- PWR_WAIT: count POWERON_CYC cycles, then INIT_LOAD.
- INIT_LOAD loads the init ROM entry at index 0..3 into lcd_rs=0/lcd_data, then SETUP. ROM contents: 0x38 function set, 0x0C display on, 0x06 entry mode, 0x01 clear.
- After EXEC_WAIT of the last init entry: init_done=1, go to IDLE.
- IDLE: req_ready=1 only when init_done=1.
  - A handshake is req_valid=1 and req_ready=1 on a rising edge.
  - On that edge, capture req_rs/req_data into lcd_rs/lcd_data, drop req_ready, go to SETUP.
  - req_valid while not ready is ignored; upstream must hold it.
- SETUP: lcd_en=0 for T_AS_CYC cycles.
- E_HIGH: lcd_en=1 for exactly T_EH_CYC cycles.
- HOLD: lcd_en=0 for T_H_CYC cycles.
- lcd_rs and lcd_data are unchanged from capture until the next capture or init load.
- EXEC_WAIT duration:
  - WAIT_LONG_CYC when lcd_rs=0 and lcd_data[7:2]=0, i.e. clear 0x01 or home 0x02/0x03.
  - Otherwise WAIT_SHORT_CYC.
  - Then INIT_LOAD (next index) or IDLE.
- Accept-to-ready latency: exactly T_AS_CYC+T_EH_CYC+T_H_CYC+WAIT cycles after the accepting edge, req_ready is 1 again. Back-to-back requests are therefore fully throttled.
- Single shared down-counter:
  - Width is ceil(log2(max parameter + 1)).
  - Loaded with N-1 on state entry; the state exits when it reaches 0.
  - A parameter value of 1 gives a 1-cycle phase. A value of 0 is illegal and is treated as 1.
- busy = (state != IDLE).

Test Plan:
- Sim params POWERON=20, T_AS=2, T_EH=4, T_H=1, SHORT=10, LONG=50 (same for all scenarios).
- Reset release -> 20 cycles of lcd_en=0, then four lcd_en pulses, each exactly 4 cycles high, with lcd_data 0x38, 0x0C, 0x06, 0x01 and lcd_rs=0. The 0x01 pulse is followed by a 50-cycle wait. init_done rises 1 cycle after that; req_ready=1.
- After init, req_valid=1, req_rs=1, req_data=0x31 held -> accepted on first edge. lcd_rs=1/lcd_data=0x31 for 2 cycles before lcd_en rises; lcd_en high 4 cycles. req_ready returns after 2+4+1+10=17 cycles.
- Command 0x80 (rs=0) -> short wait, ready after 17 cycles. Command 0x02 -> long wait, ready after 57 cycles.
- req_valid asserted during init and during E_HIGH -> no capture; lcd_data unchanged. Capture occurs only on the first edge with req_ready=1.
- reset pulled low during E_HIGH -> lcd_en=0, lcd_data=0x00, init_done=0 asynchronously (before the next clock edge). On release, the full power-on/init sequence repeats.
- 16 back-to-back characters '0'/'1' from the upstream writer -> 16 enable pulses, no overlap, each lcd_data matching the sent byte in order.
